modulator_sequencer: RTL and testbench

- Controller for the sine-PWM modulator datapath.
- Steps through a programmable table of frequency divisors and holds each for a programmed number of sine periods.
- Drives the modulator's two divisor banks and its bank-select line (ping-pong), so frequency changes happen only at period boundaries, glitch-free.
- Sits between a config master (CPU/UART bridge) and the modulator instance.

---
 rtl/modulator_seq_pkg.sv | 22 ++
 rtl/modulator_seq_table.sv | 48 ++++
 rtl/modulator_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_modulator_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modulator_seq_pkg.sv
// Shared definitions for the sine-PWM modulator sequencer: state encoding,
// divisor width and the saturating table-index helper.
package modulator_seq_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned last);
    if (idx >= last) begin
      return last;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/modulator_seq_table.sv
// Step table for the modulator sequencer: STEPS_P entries of {divisor, hold},
// synchronous write with reset, two combinational read ports.
module modulator_seq_table
  import modulator_seq_pkg::*;
#(
  parameter int unsigned      STEPS_P       = 4,
  parameter int unsigned      HOLD_W_P      = 16,
  parameter logic [DIV_W-1:0] DIV_DEFAULT_P = 32'd50000
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       we_i,
  input  logic [$clog2(STEPS_P)-1:0] wr_addr_i,
  input  logic [DIV_W-1:0]           wr_div_i,
  input  logic [HOLD_W_P-1:0]        wr_hold_i,
  input  logic [$clog2(STEPS_P)-1:0] rd_a_addr_i,
  output logic [DIV_W-1:0]           rd_a_div_o,
  output logic [HOLD_W_P-1:0]        rd_a_hold_o,
  input  logic [$clog2(STEPS_P)-1:0] rd_b_addr_i,
  output logic [DIV_W-1:0]           rd_b_div_o,
  output logic [HOLD_W_P-1:0]        rd_b_hold_o
);

  logic [DIV_W-1:0]    div_q  [STEPS_P];
  logic [HOLD_W_P-1:0] hold_q [STEPS_P];

  // Table storage: reset to default divisor with hold 0, else write on strobe.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < int'(STEPS_P); i++) begin
        div_q[i]  <= DIV_DEFAULT_P;
        hold_q[i] <= {HOLD_W_P{1'b0}};
      end
    end else if (we_i) begin
      div_q[wr_addr_i]  <= wr_div_i;
      hold_q[wr_addr_i] <= wr_hold_i;
    end else begin
      div_q  <= div_q;
      hold_q <= hold_q;
    end
  end

  assign rd_a_div_o  = div_q[rd_a_addr_i];
  assign rd_a_hold_o = hold_q[rd_a_addr_i];
  assign rd_b_div_o  = div_q[rd_b_addr_i];
  assign rd_b_hold_o = hold_q[rd_b_addr_i];

endmodule

// File: rtl/modulator_sequencer.sv
// Sequencer for the sine-PWM modulator: walks a divisor/hold table, ping-pongs
// the two divisor banks at period boundaries. Define MODSEQ_LOOP_EN for looping.
module modulator_sequencer
  import modulator_seq_pkg::*;
#(
  parameter int unsigned      STEPS_P       = 4,
  parameter int unsigned      HOLD_W_P      = 16,
  parameter logic [DIV_W-1:0] DIV_DEFAULT_P = 32'd50000
) (
  input  logic                       clk_in,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(STEPS_P)-1:0] cfg_addr,
  input  logic [DIV_W-1:0]           cfg_div,
  input  logic [HOLD_W_P-1:0]        cfg_hold,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       period_tick,
`ifdef MODSEQ_LOOP_EN
  input  logic                       loop,
`endif
  output logic [DIV_W-1:0]           div_factor_freqhigh,
  output logic [DIV_W-1:0]           div_factor_freqlow,
  output logic                       sw0,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(STEPS_P)-1:0] step_idx
);

  localparam int                   IDX_W       = $clog2(STEPS_P);
  localparam int unsigned          LAST_C      = STEPS_P - 32'd1;
  localparam logic [IDX_W-1:0]     IDX_ZERO_C  = IDX_W'(0);
  localparam logic [IDX_W-1:0]     LAST_IDX_C  = IDX_W'(STEPS_P - 32'd1);
  localparam logic [HOLD_W_P-1:0]  HOLD_ZERO_C = HOLD_W_P'(0);
  localparam logic [HOLD_W_P-1:0]  HOLD_ONE_C  = HOLD_W_P'(1);

  seq_state_e          state_q, state_d;
  logic                sw0_q, sw0_d;
  logic [DIV_W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [IDX_W-1:0]    step_q, step_d;
  logic [HOLD_W_P-1:0] hold_cnt_q, hold_cnt_d, hold_cur_q, hold_cur_d;
`ifdef MODSEQ_LOOP_EN
  logic [DIV_W-1:0]    div0_q, div0_d, arm_pre_q, arm_pre_d;
  logic [HOLD_W_P-1:0] hold0_q, hold0_d;
  logic                b_final;
`endif

  logic [IDX_W-1:0]    step_nxt, rd_a_addr, rd_b_addr;
  logic [DIV_W-1:0]    rd_a_div, rd_b_div, pre_val;
  logic [HOLD_W_P-1:0] rd_a_hold, rd_b_hold;
  logic                b_exists, last_step, pre_en;

  // Port A looks one entry ahead (entry 0 while idle), port B two ahead.
  assign step_nxt  = IDX_W'(next_idx(32'(step_q), LAST_C));
  assign rd_a_addr = (state_q == ST_IDLE) ? IDX_ZERO_C : step_nxt;
  assign rd_b_addr = IDX_W'(next_idx(32'(step_nxt), LAST_C));
  assign b_exists  = (32'(step_q) + 32'd2) <= LAST_C;
  assign last_step = (step_q == LAST_IDX_C) || (rd_a_hold == HOLD_ZERO_C);
`ifdef MODSEQ_LOOP_EN
  assign b_final   = !b_exists || (rd_b_hold == HOLD_ZERO_C);
`else
  logic unused_rd_b_hold;
  assign unused_rd_b_hold = ^rd_b_hold;
`endif

  modulator_seq_table #(
    .STEPS_P      (STEPS_P),
    .HOLD_W_P     (HOLD_W_P),
    .DIV_DEFAULT_P(DIV_DEFAULT_P)
  ) u_table (
    .clk_in     (clk_in),
    .rst        (rst),
    .we_i       (cfg_we && (state_q == ST_IDLE)),
    .wr_addr_i  (cfg_addr),
    .wr_div_i   (cfg_div),
    .wr_hold_i  (cfg_hold),
    .rd_a_addr_i(rd_a_addr),
    .rd_a_div_o (rd_a_div),
    .rd_a_hold_o(rd_a_hold),
    .rd_b_addr_i(rd_b_addr),
    .rd_b_div_o (rd_b_div),
    .rd_b_hold_o(rd_b_hold)
  );

  // Next-state and next-output logic of the sequencing FSM.
  always_comb begin
    state_d    = state_q;
    sw0_d      = sw0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    step_d     = step_q;
    hold_cnt_d = hold_cnt_q;
    hold_cur_d = hold_cur_q;
    pre_en     = 1'b0;
    pre_val    = rd_a_div;
`ifdef MODSEQ_LOOP_EN
    div0_d     = div0_q;
    hold0_d    = hold0_q;
    arm_pre_d  = arm_pre_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (rd_a_hold == HOLD_ZERO_C) begin
            done_d = 1'b1;
          end else begin
            state_d    = ST_ARM;
            step_d     = IDX_ZERO_C;
            hold_cur_d = rd_a_hold;
            pre_en     = 1'b1;
            pre_val    = rd_a_div;
`ifdef MODSEQ_LOOP_EN
            div0_d     = rd_a_div;
            hold0_d    = rd_a_hold;
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (period_tick) begin
          state_d    = ST_RUN;
          sw0_d      = ~sw0_q;
          hold_cnt_d = HOLD_ONE_C;
          pre_en     = 1'b1;
`ifdef MODSEQ_LOOP_EN
          // Remember what step 0's entry preloads so a wrap can repeat it.
          arm_pre_d  = (rd_a_hold == HOLD_ZERO_C) ? div0_q : rd_a_div;
          pre_val    = loop ? arm_pre_d : rd_a_div;
`else
          pre_val    = rd_a_div;
`endif
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (period_tick) begin
          if (hold_cnt_q != hold_cur_q) begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE_C;
          end else if (last_step) begin
`ifdef MODSEQ_LOOP_EN
            if (loop) begin
              sw0_d      = ~sw0_q;
              step_d     = IDX_ZERO_C;
              hold_cnt_d = HOLD_ONE_C;
              hold_cur_d = hold0_q;
              pre_en     = 1'b1;
              pre_val    = arm_pre_q;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            sw0_d      = ~sw0_q;
            step_d     = step_nxt;
            hold_cnt_d = HOLD_ONE_C;
            hold_cur_d = rd_a_hold;
`ifdef MODSEQ_LOOP_EN
            if (loop && b_final) begin
              pre_en  = 1'b1;
              pre_val = div0_q;
            end else begin
              pre_en  = b_exists;
              pre_val = rd_b_div;
            end
`else
            pre_en  = b_exists;
            pre_val = rd_b_div;
`endif
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The preload always targets the bank that is inactive after this edge.
    if (pre_en) begin
      if (sw0_d) begin
        lo_d = pre_val;
      end else begin
        hi_d = pre_val;
      end
    end else begin
      hi_d = hi_q;
      lo_d = lo_q;
    end
    busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sw0_q      <= 1'b0;
      hi_q       <= DIV_DEFAULT_P;
      lo_q       <= DIV_DEFAULT_P;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      step_q     <= IDX_ZERO_C;
      hold_cnt_q <= HOLD_ZERO_C;
      hold_cur_q <= HOLD_ZERO_C;
`ifdef MODSEQ_LOOP_EN
      div0_q     <= DIV_DEFAULT_P;
      arm_pre_q  <= DIV_DEFAULT_P;
      hold0_q    <= HOLD_ZERO_C;
`endif
    end else begin
      state_q    <= state_d;
      sw0_q      <= sw0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      step_q     <= step_d;
      hold_cnt_q <= hold_cnt_d;
      hold_cur_q <= hold_cur_d;
`ifdef MODSEQ_LOOP_EN
      div0_q     <= div0_d;
      arm_pre_q  <= arm_pre_d;
      hold0_q    <= hold0_d;
`endif
    end
  end

  assign div_factor_freqhigh = hi_q;
  assign div_factor_freqlow  = lo_q;
  assign sw0                 = sw0_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign step_idx            = step_q;

endmodule

// File: tb/tb_modulator_sequencer.sv
// Self-checking bench for modulator_sequencer: directed scenarios plus random
// tables against a schedule-level reference model (loop test with MODSEQ_LOOP_EN).
module tb_modulator_sequencer;

  localparam int STEPS = 4;

  logic        clk_in = 1'b0;
  logic        rst, cfg_we, start, abort, period_tick;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_div;
  logic [15:0] cfg_hold;
  logic [31:0] div_factor_freqhigh, div_factor_freqlow;
  logic        sw0, busy, done;
  logic [1:0]  step_idx;
`ifdef MODSEQ_LOOP_EN
  logic        loop;
`endif

  always #5 clk_in = ~clk_in;

  modulator_sequencer #(.STEPS_P(4), .HOLD_W_P(16), .DIV_DEFAULT_P(32'd50000)) dut (
    .clk_in(clk_in), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_div(cfg_div),
    .cfg_hold(cfg_hold), .start(start), .abort(abort), .period_tick(period_tick),
`ifdef MODSEQ_LOOP_EN
    .loop(loop),
`endif
    .div_factor_freqhigh(div_factor_freqhigh), .div_factor_freqlow(div_factor_freqlow),
    .sw0(sw0), .busy(busy), .done(done), .step_idx(step_idx)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: table contents, bank contents, active bank and step.
  logic [31:0] m_div  [STEPS];
  logic [15:0] m_hold [STEPS];
  logic [31:0] m_bank [2];
  logic        m_sw;
  logic [1:0]  m_step;

  function automatic logic [68:0] obs();
    return {sw0, div_factor_freqhigh, div_factor_freqlow, busy, done, step_idx};
  endfunction

  function automatic logic [68:0] expv(input logic b, input logic d);
    return {m_sw, m_bank[1], m_bank[0], b, d, m_step};
  endfunction

  function automatic int m_len();
    int n = 0;
    while (n < STEPS && m_hold[n] != 16'd0) n++;
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < STEPS; i++) begin
      m_div[i]  = 32'd50000;
      m_hold[i] = 16'd0;
    end
    m_bank[0] = 32'd50000;
    m_bank[1] = 32'd50000;
    m_sw      = 1'b0;
    m_step    = 2'd0;
  endtask

  task automatic m_start();
    m_bank[m_sw ? 0 : 1] = m_div[0];
    m_step = 2'd0;
  endtask

  // Entering step s: flip bank, preload the entry that will follow s.
  task automatic m_enter(input int s, input bit looping);
    int n = m_len();
    m_sw   = ~m_sw;
    m_step = 2'(s);
    if (looping) begin
      m_bank[m_sw ? 0 : 1] = m_div[(s + 1 < n) ? s + 1 : 0];
    end else if (s + 1 < STEPS) begin
      m_bank[m_sw ? 0 : 1] = m_div[s + 1];
    end
  endtask

  task automatic tick_clk();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick_clk();
  endtask

  task automatic prog(input int a, input logic [31:0] d, input logic [15:0] h, input bit upd);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_div = d; cfg_hold = h;
    tick_clk();
    cfg_we = 1'b0;
    if (upd) begin
      m_div[a]  = d;
      m_hold[a] = h;
    end
  endtask

  task automatic pulse_tick(input int gap);
    idle(gap);
    period_tick = 1'b1;
    tick_clk();
    period_tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick_clk();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    m_reset();
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin
      failures++; $display("FAIL reset got=%h exp=%h", obs(), expv(1'b0, 1'b0));
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    prog(0, 32'd1000, 16'd2, 1'b1);
    prog(1, 32'd2000, 16'd1, 1'b1);
    prog(2, 32'd3000, 16'd0, 1'b1);
    pulse_start(); m_start();
    checks++;
    if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL basic_start got=%h exp=%h", obs(), expv(1'b1, 1'b0)); end
    pulse_tick(1); m_enter(0, 1'b0);
    checks++;
    if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL basic_tick1 got=%h exp=%h", obs(), expv(1'b1, 1'b0)); end
    pulse_tick(0);
    checks++;
    if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL basic_tick2 got=%h exp=%h", obs(), expv(1'b1, 1'b0)); end
    pulse_tick(2); m_enter(1, 1'b0);
    checks++;
    if (obs() !== expv(1'b1, 1'b0) || div_factor_freqlow !== 32'd2000) begin
      failures++; $display("FAIL basic_tick3 got=%h exp=%h", obs(), expv(1'b1, 1'b0));
    end
    pulse_tick(1);
    checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin failures++; $display("FAIL basic_done got=%h exp=%h", obs(), expv(1'b0, 1'b1)); end
    tick_clk();
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL basic_after got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
    pulse_tick(0);
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL basic_idle_tick got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
  endtask

  task automatic test_empty();
    prog(0, 32'd4444, 16'd0, 1'b1);
    pulse_start();
    checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin failures++; $display("FAIL empty_done got=%h exp=%h", obs(), expv(1'b0, 1'b1)); end
    tick_clk();
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL empty_after got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
  endtask

  task automatic test_abort();
    prog(0, 32'd1000, 16'd2, 1'b1);
    prog(1, 32'd2000, 16'd1, 1'b1);
    start = 1'b1; abort = 1'b1;
    tick_clk();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL abort_beats_start got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
    pulse_start(); m_start();
    abort = 1'b1; period_tick = 1'b1;
    tick_clk();
    abort = 1'b0; period_tick = 1'b0;
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL abort_arm got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
    pulse_start(); m_start();
    pulse_tick(1); m_enter(0, 1'b0);
    pulse_tick(0);
    abort = 1'b1; period_tick = 1'b1;
    tick_clk();
    abort = 1'b0; period_tick = 1'b0;
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL abort_run got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
    pulse_tick(1); pulse_tick(0);
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL abort_frozen got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
  endtask

  task automatic test_illegal();
    prog(2, 32'd3000, 16'd0, 1'b1);
    pulse_start(); m_start();
    prog(1, 32'd7777, 16'd3, 1'b0);
    pulse_tick(0); m_enter(0, 1'b0);
    prog(2, 32'd8888, 16'd4, 1'b0);
    pulse_start();
    checks++;
    if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL illegal_start_busy got=%h exp=%h", obs(), expv(1'b1, 1'b0)); end
    pulse_tick(1);
    pulse_tick(0); m_enter(1, 1'b0);
    checks++;
    if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL illegal_switch got=%h exp=%h", obs(), expv(1'b1, 1'b0)); end
    pulse_tick(2);
    checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin failures++; $display("FAIL illegal_done got=%h exp=%h", obs(), expv(1'b0, 1'b1)); end
    tick_clk();
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int n;
      for (int i = 0; i < STEPS; i++) begin
        logic [15:0] h;
        if (i == 0) h = (it == 3) ? 16'd0 : 16'($urandom_range(1, 3));
        else        h = 16'($urandom_range(0, 3));
        prog(i, $urandom, h, 1'b1);
      end
      n = m_len();
      pulse_start();
      if (n == 0) begin
        checks++;
        if (obs() !== expv(1'b0, 1'b1)) begin failures++; $display("FAIL rand_empty it=%0d got=%h exp=%h", it, obs(), expv(1'b0, 1'b1)); end
        tick_clk();
        continue;
      end
      m_start();
      checks++;
      if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL rand_start it=%0d got=%h exp=%h", it, obs(), expv(1'b1, 1'b0)); end
      pulse_tick(int'($urandom_range(0, 2))); m_enter(0, 1'b0);
      checks++;
      if (obs() !== expv(1'b1, 1'b0)) begin failures++; $display("FAIL rand_first it=%0d got=%h exp=%h", it, obs(), expv(1'b1, 1'b0)); end
      for (int s = 0; s < n; s++) begin
        for (int h = 1; h <= int'(m_hold[s]); h++) begin
          logic eb, ed;
          pulse_tick(int'($urandom_range(0, 2)));
          eb = 1'b1; ed = 1'b0;
          if (h == int'(m_hold[s])) begin
            if (s + 1 < n) m_enter(s + 1, 1'b0);
            else begin eb = 1'b0; ed = 1'b1; end
          end
          checks++;
          if (obs() !== expv(eb, ed)) begin
            failures++; $display("FAIL rand_tick it=%0d s=%0d h=%0d got=%h exp=%h", it, s, h, obs(), expv(eb, ed));
          end
        end
      end
      tick_clk();
      checks++;
      if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL rand_end it=%0d got=%h exp=%h", it, obs(), expv(1'b0, 1'b0)); end
    end
  endtask

`ifdef MODSEQ_LOOP_EN
  task automatic test_loop();
    loop = 1'b1;
    prog(0, 32'd1000, 16'd2, 1'b1);
    prog(1, 32'd2000, 16'd1, 1'b1);
    prog(2, 32'd3000, 16'd0, 1'b1);
    pulse_start(); m_start();
    pulse_tick(1); m_enter(0, 1'b1);
    for (int l = 0; l < 3; l++) begin
      for (int s = 0; s < 2; s++) begin
        for (int h = 1; h <= int'(m_hold[s]); h++) begin
          pulse_tick(int'($urandom_range(0, 1)));
          if (h == int'(m_hold[s])) m_enter((s + 1) % 2, 1'b1);
          checks++;
          if (obs() !== expv(1'b1, 1'b0)) begin
            failures++; $display("FAIL loop l=%0d s=%0d got=%h exp=%h", l, s, obs(), expv(1'b1, 1'b0));
          end
        end
      end
    end
    abort = 1'b1;
    tick_clk();
    abort = 1'b0;
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL loop_abort got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
    loop = 1'b0;
  endtask
`endif

  task automatic test_reset_mid();
    prog(0, 32'd1234, 16'd3, 1'b1);
    prog(1, 32'd5678, 16'd2, 1'b1);
    pulse_start(); m_start();
    pulse_tick(0); m_enter(0, 1'b0);
    rst = 1'b1;
    tick_clk();
    rst = 1'b0;
    m_reset();
    checks++;
    if (obs() !== expv(1'b0, 1'b0)) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs(), expv(1'b0, 1'b0)); end
    pulse_start();
    checks++;
    if (obs() !== expv(1'b0, 1'b1)) begin failures++; $display("FAIL reset_table got=%h exp=%h", obs(), expv(1'b0, 1'b1)); end
    tick_clk();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_div = 32'd0; cfg_hold = 16'd0;
    start = 1'b0; abort = 1'b0; period_tick = 1'b0;
`ifdef MODSEQ_LOOP_EN
    loop = 1'b0;
`endif
    test_reset();
    test_basic();
    test_empty();
    test_abort();
    test_illegal();
    test_random();
`ifdef MODSEQ_LOOP_EN
    test_loop();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
